// File: rtl/ram_pkg.sv
// Shared types and helpers for the sized, handshaked byte RAM.
package ram_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } access_size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACC,
    DONE
  } state_e;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  // Lane k addresses byte a+k; lane 0 is the most significant byte.
  function automatic logic [3:0] lane_we(input access_size_e s);
    case (s)
      SZ_BYTE: lane_we = 4'b0001;
      SZ_HALF: lane_we = 4'b0011;
      SZ_WORD: lane_we = 4'b1111;
      default: lane_we = 4'b0000;
    endcase
  endfunction

  // Natural alignment rule; the reserved size is always treated as misaligned.
  function automatic logic is_misaligned(input access_size_e s, input logic [1:0] a_lo);
    case (s)
      SZ_HALF: is_misaligned = a_lo[0];
      SZ_WORD: is_misaligned = |a_lo;
      SZ_RSVD: is_misaligned = 1'b1;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram_byte_bank.sv
// DEPTH x 8 storage exposed as four byte lanes at a, a+1, a+2, a+3 (mod DEPTH).
// Lane 0 maps to bits [31:24]. Storage is not reset.
module ram_byte_bank #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_we,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] w_lane_addr [4];

  // Per-lane addresses; ADDR_W-bit arithmetic gives the modulo-DEPTH wrap.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      w_lane_addr[k] = i_addr + ADDR_W'(k);
    end
  end

  // Byte-lane writes with individual enables.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (i_we[k]) begin
        r_mem[w_lane_addr[k]] <= i_wdata[(3 - k) * 8 +: 8];
      end
    end
  end

  // Asynchronous read of all four lanes.
  always_comb begin
    o_rdata = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      o_rdata[(3 - k) * 8 +: 8] = r_mem[w_lane_addr[k]];
    end
  end

endmodule

// File: rtl/ram_sized_hs.sv
// Byte-addressed big-endian RAM with byte/half/word access and MV/MOC handshake.
// Optional macro ALIGN_CHECK_EN adds the align_err port and misalignment blocking.
module ram_sized_hs
  import ram_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mv,
  input  logic              rw,
  input  logic [1:0]        type_data,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
`ifdef ALIGN_CHECK_EN
  output logic              align_err,
`endif
  output logic              moc
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_rw;
  access_size_e      r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_moc;
  logic [31:0]       r_dout;
  logic              w_mis;
  logic [3:0]        w_we;
  logic [31:0]       w_bank_wdata;
  logic [31:0]       w_bank_rdata;
  logic [31:0]       w_rd_fmt;

`ifdef ALIGN_CHECK_EN
  logic r_aerr;
  assign w_mis     = is_misaligned(r_size, r_addr[1:0]);
  assign align_err = r_aerr;
`else
  assign w_mis = 1'b0;
`endif

  assign moc      = r_moc;
  assign data_out = r_dout;

  // State register and wait counter; counter runs only while in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == WAIT) ? r_cnt + 4'd1 : '0;
    end
  end

  // Next-state logic. WAIT is entered on the latch edge and left once the
  // counter equals WAIT_CYC, which gives a WAIT_CYC+2 edge request-to-moc latency.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (mv) w_state_nxt = WAIT;
      WAIT:    if (r_cnt == LP_WAIT) w_state_nxt = ACC;
      ACC:     w_state_nxt = DONE;
      DONE:    if (!mv) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch: captured on the edge that accepts mv in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw    <= RD;
      r_size  <= SZ_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && mv) begin
      r_rw    <= rw;
      r_size  <= access_size_e'(type_data);
      r_addr  <= address;
      r_wdata <= data_in;
    end
  end

  // Lane enables and big-endian placement of right-justified write data.
  always_comb begin
    w_we = '0;
    if (r_state == ACC && r_rw == WR && !w_mis) begin
      w_we = lane_we(r_size);
    end
    case (r_size)
      SZ_BYTE: w_bank_wdata = {r_wdata[7:0], 24'b0};
      SZ_HALF: w_bank_wdata = {r_wdata[15:0], 16'b0};
      default: w_bank_wdata = r_wdata;
    endcase
  end

  // Right-justify and zero-extend read lanes; reserved size reads as zero.
  always_comb begin
    case (r_size)
      SZ_BYTE: w_rd_fmt = {24'b0, w_bank_rdata[31:24]};
      SZ_HALF: w_rd_fmt = {16'b0, w_bank_rdata[31:16]};
      SZ_WORD: w_rd_fmt = w_bank_rdata;
      default: w_rd_fmt = '0;
    endcase
  end

  // Registered handshake and read data; moc follows entry to / residence in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_moc  <= 1'b0;
      r_dout <= '0;
    end else begin
      r_moc <= (w_state_nxt == DONE);
      if (r_state == ACC && r_rw == RD && !w_mis) begin
        r_dout <= w_rd_fmt;
      end
    end
  end

`ifdef ALIGN_CHECK_EN
  // Misalignment flag shares moc's lifetime.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aerr <= 1'b0;
    end else begin
      r_aerr <= (w_state_nxt == DONE) && w_mis;
    end
  end
`endif

  ram_byte_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk    (clk),
    .i_addr (r_addr),
    .i_we   (w_we),
    .i_wdata(w_bank_wdata),
    .o_rdata(w_bank_rdata)
  );

endmodule
